// File: rtl/i2c_master_seq.sv
// i2c_master_seq: byte-level I2C master sequencer.
// Accepts START/WRITE/READ/STOP commands over a valid/ready port. It drives
// the open-drain enables with quarter-period SCL timing and honours slave
// clock stretching. It returns one response per accepted command.
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   cmd_valid/cmd_ready               - command handshake
//   cmd_op/cmd_data/cmd_nack          - opcode, write byte, read ACK bit
//   rsp_valid/rsp_data/rsp_ack/rsp_err - one-cycle response and its payload
//   busy                              - bus owned (not IDLE)
//   scl_oe/sda_oe                     - 1 = release line, 0 = drive low
//   scl_in/sda_in                     - resolved bus levels
module i2c_master_seq #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HOLD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_RSTART = 3'd3;
    localparam logic [2:0] S_BIT    = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [2:0]       qtr_q, qtr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       data_q, data_d;
    logic             nack_q, nack_d;
    logic [8:0]       rx_q, rx_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_ack_q, rsp_ack_d;
    logic             rsp_err_q, rsp_err_d;

    logic       stall;
    logic       qend;
    logic       done;
    logic [2:0] last_qtr;
    logic       bit_val;

    // Next-state, counters, response and next line levels
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        op_d        = op_q;
        data_d      = data_q;
        nack_d      = nack_q;
        rx_d        = rx_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_ack_d   = rsp_ack_q;
        rsp_err_d   = rsp_err_q;
        done        = 1'b0;
        bit_val     = 1'b1;
        scl_oe_d    = 1'b1;
        sda_oe_d    = 1'b1;

        // A released SCL still read low means a slave is stretching the clock
        stall = scl_oe_q && !scl_in && (state_q != S_IDLE) && (state_q != S_HOLD);
        qend  = (cnt_q == CNT_LAST) && !stall;

        case (state_q)
            S_START:  last_qtr = 3'd2;
            S_RSTART: last_qtr = 3'd4;
            S_BIT:    last_qtr = 3'd3;
            default:  last_qtr = 3'd2;
        endcase

        case (state_q)
            S_IDLE, S_HOLD: begin
                cnt_d = '0;
                qtr_d = '0;
                bit_d = '0;
                // cmd_ready is high in both of these states
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    nack_d = cmd_nack;
                    if (cmd_op == OP_START) begin
                        state_d = (state_q == S_IDLE) ? S_START : S_RSTART;
                    end else if (state_q == S_IDLE) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_ack_d   = 1'b0;
                    end else begin
                        state_d = (cmd_op == OP_WRITE || cmd_op == OP_READ) ? S_BIT : S_STOP;
                    end
                end
            end
            default: begin
                if (!stall) begin
                    cnt_d = qend ? '0 : cnt_q + CNT_W'(1);
                end
                if (qend) begin
                    if (qtr_q == last_qtr) begin
                        qtr_d = '0;
                        if (state_q == S_BIT) begin
                            // Sample in the last cycle of the SCL-high quarter
                            rx_d = {rx_q[7:0], sda_in};
                            if (bit_q == 4'd8) begin
                                done = 1'b1;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end else begin
                            done = 1'b1;
                        end
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
                if (done) begin
                    state_d     = (state_q == S_STOP) ? S_IDLE : S_HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = (op_q == OP_READ) ? rx_d[8:1] : 8'h00;
                    rsp_ack_d   = (op_q == OP_WRITE) ? rx_d[0] :
                                  (op_q == OP_READ)  ? nack_q  : 1'b0;
                end
            end
        endcase

        // SDA level of the bit about to be driven; 1 releases for slave data/ACK
        if (op_d == OP_WRITE && bit_d < 4'd8) begin
            bit_val = data_d[3'(4'd7 - bit_d)];
        end else if (op_d == OP_READ && bit_d == 4'd8) begin
            bit_val = nack_d;
        end

        // Line levels follow the state/quarter being entered
        case (state_d)
            S_IDLE: begin
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b1;
            end
            S_START: begin
                scl_oe_d = (qtr_d < 3'd2);
                sda_oe_d = 1'b0;
            end
            S_RSTART: begin
                scl_oe_d = (qtr_d != 3'd0) && (qtr_d != 3'd4);
                sda_oe_d = (qtr_d < 3'd2);
            end
            S_BIT: begin
                scl_oe_d = (qtr_d >= 3'd2);
                sda_oe_d = bit_val;
            end
            S_STOP: begin
                scl_oe_d = (qtr_d != 3'd0);
                sda_oe_d = (qtr_d == 3'd2);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            qtr_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            op_q        <= '0;
            data_q      <= '0;
            nack_q      <= 1'b0;
            rx_q        <= '0;
            scl_oe_q    <= 1'b1;
            sda_oe_q    <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            op_q        <= op_d;
            data_q      <= data_d;
            nack_q      <= nack_d;
            rx_q        <= rx_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ack   = rsp_ack_q;
    assign rsp_err   = rsp_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: directed self-checking bench for i2c_master_seq.
// A small slave model pulls SDA low per a 9-bit pattern indexed by SCL falls
// and can stretch SCL for a number of cycles at a chosen bit.
module tb_i2c_master_seq;
    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_ack, rsp_err, busy, scl_oe, sda_oe;
    logic [7:0] rsp_data;
    logic       scl_in, sda_in;

    int checks = 0;
    int failures = 0;

    // Slave model configuration and state
    logic       slave_en = 1'b0;
    logic [8:0] slave_pat = 9'h1FF;
    int         st_bit = 0;
    int         st_len = 0;
    int         fall_cnt = 0;
    int         st_cnt = 0;
    logic       scl_prev = 1'b1;
    logic       stretch_active, slave_sda;

    // Bus monitor
    logic       mscl = 1'b1;
    logic       msda = 1'b1;
    int         tog_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         mon_cnt = 0;
    logic [8:0] mon_bits = 9'h000;

    // Per-command capture
    logic       wave_scl [0:255];
    logic       wave_sda [0:255];
    logic [7:0] r_data;
    logic       r_ack, r_err;

    always #5 clk = ~clk;

    i2c_master_seq #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    assign stretch_active = slave_en && (st_len > 0) && (fall_cnt == st_bit) && (st_cnt < st_len);
    assign slave_sda      = (slave_en && fall_cnt <= 8) ? slave_pat[4'(8 - fall_cnt)] : 1'b1;
    assign scl_in         = scl_oe & ~stretch_active;
    assign sda_in         = sda_oe & slave_sda;

    // Slave bit index = SCL falls since acceptance; stretch cycle counter
    always @(posedge clk) begin
        scl_prev <= scl_oe;
        if (!slave_en) begin
            fall_cnt <= 0;
            st_cnt   <= 0;
        end else begin
            if (scl_prev && !scl_oe) fall_cnt <= fall_cnt + 1;
            if (stretch_active && scl_oe) st_cnt <= st_cnt + 1;
        end
    end

    // Bus edge monitor, sampled away from the active edge
    always @(negedge clk) begin
        mscl <= scl_oe;
        msda <= sda_oe;
        if (scl_oe != mscl || sda_oe != msda) tog_cnt <= tog_cnt + 1;
        if (!mscl && scl_oe) begin
            mon_bits <= {mon_bits[7:0], sda_oe};
            mon_cnt  <= mon_cnt + 1;
        end
        if (mscl && scl_oe && msda && !sda_oe) start_cnt <= start_cnt + 1;
        if (mscl && scl_oe && !msda && sda_oe) stop_cnt <= stop_cnt + 1;
    end

    // Issue one command (called #1 after an edge) and wait for its response
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic nack,
                          input logic [8:0] pat, input int sbit, input int slen,
                          output int lat);
        slave_en  = 1'b0;
        slave_pat = pat;
        st_bit    = sbit;
        st_len    = slen;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_nack  = nack;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        slave_en  = 1'b1;
        lat = 1;
        wave_scl[0] = scl_oe;
        wave_sda[0] = sda_oe;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat <= 256) begin
                wave_scl[8'(lat - 1)] = scl_oe;
                wave_sda[8'(lat - 1)] = sda_oe;
            end
        end
        r_data = rsp_data;
        r_ack  = rsp_ack;
        r_err  = rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({scl_oe, sda_oe} !== 2'b11) begin failures++; $display("FAIL reset_lines got=%b exp=11", {scl_oe, sda_oe}); end
        checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL reset_ready_busy got=%b exp=10", {cmd_ready, busy}); end
        checks++; if ({rsp_valid, rsp_ack, rsp_err} !== 3'b000) begin failures++; $display("FAIL reset_rsp got=%b exp=000", {rsp_valid, rsp_ack, rsp_err}); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_error_idle();
        int lat;
        int t0;
        t0 = tog_cnt;
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL err_stop_lat got=%0d exp=1", lat); end
        checks++; if ({r_err, r_ack} !== 2'b10) begin failures++; $display("FAIL err_stop_flags got=%b exp=10", {r_err, r_ack}); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("FAIL err_stop_data got=%h exp=00", r_data); end
        do_cmd(2'd1, 8'hFF, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 1 || r_err !== 1'b1) begin failures++; $display("FAIL err_write lat=%0d err=%b exp lat=1 err=1", lat, r_err); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (tog_cnt !== t0) begin failures++; $display("FAIL err_no_toggle got=%0d exp=%0d", tog_cnt, t0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write_ack();
        int lat;
        int sc, mc, sp;
        sc = start_cnt;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 13) begin failures++; $display("FAIL start_lat got=%0d exp=13", lat); end
        checks++; if (start_cnt !== sc + 1) begin failures++; $display("FAIL start_cond got=%0d exp=%0d", start_cnt, sc + 1); end
        checks++; if ({wave_scl[0], wave_sda[0], wave_scl[8], wave_sda[8]} !== 4'b1000) begin failures++; $display("FAIL start_wave got=%b exp=1000", {wave_scl[0], wave_sda[0], wave_scl[8], wave_sda[8]}); end
        checks++; if ({cmd_ready, busy, r_err} !== 3'b110) begin failures++; $display("FAIL start_state got=%b exp=110", {cmd_ready, busy, r_err}); end
        mc = mon_cnt;
        do_cmd(2'd1, 8'hA5, 1'b0, 9'b1_1111_1110, 0, 0, lat);
        checks++; if (lat !== 145) begin failures++; $display("FAIL write_lat got=%0d exp=145", lat); end
        checks++; if (mon_cnt !== mc + 9 || mon_bits !== 9'b1010_0101_1) begin failures++; $display("FAIL write_bits got=%b n=%0d exp=101001011 n=9", mon_bits, mon_cnt - mc); end
        checks++; if ({r_ack, r_err, r_data} !== {1'b0, 1'b0, 8'h00}) begin failures++; $display("FAIL write_rsp got ack=%b err=%b data=%h exp 0 0 00", r_ack, r_err, r_data); end
        sp = stop_cnt;
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 13) begin failures++; $display("FAIL stop_lat got=%0d exp=13", lat); end
        checks++; if (stop_cnt !== sp + 1) begin failures++; $display("FAIL stop_cond got=%0d exp=%0d", stop_cnt, sp + 1); end
        checks++; if ({wave_scl[0], wave_sda[0], wave_scl[4], wave_sda[4], wave_scl[8], wave_sda[8]} !== 6'b001011) begin failures++; $display("FAIL stop_wave got=%b exp=001011", {wave_scl[0], wave_sda[0], wave_scl[4], wave_sda[4], wave_scl[8], wave_sda[8]}); end
        checks++; if ({scl_oe, sda_oe, busy} !== 3'b110) begin failures++; $display("FAIL stop_end got=%b exp=110", {scl_oe, sda_oe, busy}); end
    endtask

    task automatic test_read_nack();
        int lat;
        int mc;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        mc = mon_cnt;
        do_cmd(2'd2, 8'h00, 1'b1, {8'h3C, 1'b1}, 0, 0, lat);
        checks++; if (lat !== 145) begin failures++; $display("FAIL read_lat got=%0d exp=145", lat); end
        checks++; if (r_data !== 8'h3C) begin failures++; $display("FAIL read_data got=%h exp=3c", r_data); end
        checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL read_ack got=%b exp=1", r_ack); end
        checks++; if (mon_cnt !== mc + 9 || mon_bits !== 9'h1FF) begin failures++; $display("FAIL read_sda_released got=%b n=%0d exp=111111111 n=9", mon_bits, mon_cnt - mc); end
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
    endtask

    task automatic test_no_slave();
        int lat;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        do_cmd(2'd1, 8'h5A, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 145 || r_ack !== 1'b1) begin failures++; $display("FAIL noslave lat=%0d ack=%b exp lat=145 ack=1", lat, r_ack); end
    endtask

    task automatic test_rstart();
        int lat;
        int sc;
        checks++; if ({cmd_ready, busy} !== 2'b11) begin failures++; $display("FAIL rstart_hold got=%b exp=11", {cmd_ready, busy}); end
        sc = start_cnt;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        checks++; if (lat !== 5 * CLK_DIV + 1) begin failures++; $display("FAIL rstart_lat got=%0d exp=%0d", lat, 5 * CLK_DIV + 1); end
        checks++; if ({wave_scl[0], wave_sda[0], wave_scl[4], wave_sda[4], wave_scl[8], wave_sda[8], wave_scl[16], wave_sda[16]} !== 8'b01111000) begin failures++; $display("FAIL rstart_wave got=%b exp=01111000", {wave_scl[0], wave_sda[0], wave_scl[4], wave_sda[4], wave_scl[8], wave_sda[8], wave_scl[16], wave_sda[16]}); end
        checks++; if (start_cnt !== sc + 1) begin failures++; $display("FAIL rstart_cond got=%0d exp=%0d", start_cnt, sc + 1); end
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
    endtask

    task automatic test_stretch();
        int lat;
        int mc;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        mc = mon_cnt;
        do_cmd(2'd1, 8'hA5, 1'b0, 9'b1_1111_1110, 3, 37, lat);
        checks++; if (lat !== 145 + 37) begin failures++; $display("FAIL stretch_lat got=%0d exp=%0d", lat, 145 + 37); end
        checks++; if (mon_cnt !== mc + 9 || mon_bits !== 9'b1010_0101_1) begin failures++; $display("FAIL stretch_bits got=%b n=%0d exp=101001011 n=9", mon_bits, mon_cnt - mc); end
        checks++; if (r_ack !== 1'b0) begin failures++; $display("FAIL stretch_ack got=%b exp=0", r_ack); end
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
    endtask

    task automatic test_reset_mid_read();
        int lat;
        int rv;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 0, 0, lat);
        slave_en  = 1'b0;
        slave_pat = 9'h000;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_nack  = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        slave_en  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midread_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({scl_oe, sda_oe, busy, rsp_valid} !== 4'b1100) begin failures++; $display("FAIL midread_reset got=%b exp=1100", {scl_oe, sda_oe, busy, rsp_valid}); end
        rv = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rv++;
        end
        checks++; if (rv !== 0) begin failures++; $display("FAIL midread_no_rsp got=%0d exp=0", rv); end
        checks++; if ({cmd_ready, scl_oe, sda_oe} !== 3'b111) begin failures++; $display("FAIL midread_idle got=%b exp=111", {cmd_ready, scl_oe, sda_oe}); end
    endtask

    initial begin
        test_reset();
        test_error_idle();
        test_write_ack();
        test_read_nack();
        test_no_slave();
        test_rstart();
        test_stretch();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
